// File: rtl/lab62_key_conditioner.sv
// -----------------------------------------------------------------------------
// lab62_key_conditioner
//
// Turns one raw, bouncing pushbutton pin into a clean debounced level for the
// SoC's 1-bit PIO in_port ("add/accumulate" key). Also produces one-cycle
// press/release strobes and a wrapping press counter for local logic / LEDs.
//
// Ports:
//   clk           in   system clock (50 MHz), rising edge
//   reset_n       in   asynchronous active-low reset
//   key_raw       in   raw pushbutton pin, asynchronous and bouncing
//   clear_count   in   synchronous, level-sensitive clear of press_count
//   btn_level     out  debounced state, 1 = pressed (also the FSM state bit)
//   press_pulse   out  one-cycle strobe, first cycle of btn_level == 1
//   release_pulse out  one-cycle strobe, first cycle of btn_level == 0
//   press_count   out  accepted presses, wraps modulo 2^PCOUNT_W
//
// Latency: pin stable from edge k -> btn_level changes on edge
// k + 1 + DEBOUNCE_CYCLES. Any sample equal to the current state restarts
// the count, so a single bounce costs the whole window again.
// -----------------------------------------------------------------------------
module lab62_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned PCOUNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                key_raw,
    input  logic                clear_count,
    output logic                btn_level,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic [PCOUNT_W-1:0] press_count
);

    // Count value on which the stable window is complete.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    logic             pressed_n;
    logic             sync1;
    logic             sync2;

    // Normalise polarity before synchronising so everything downstream
    // reads 1 = pressed.
    assign pressed_n = ACTIVE_LOW ? ~key_raw : key_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pressed_n;
            sync2 <= sync1;
        end
    end

    // State register, debounce counter and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Next-state logic. Both states are mirror images: a sample that differs
    // from the current state advances cnt, a sample that agrees clears it.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (sync2) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_PRESSED;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ST_PRESSED: begin
                if (!sync2) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt   = ST_RELEASED;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
            end
        endcase
    end

    // A press accepted on the same edge as a clear wins over the clear and
    // leaves the counter at 1, so no press is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count <= '0;
        end else if (press_nxt) begin
            press_count <= clear_count ? PCOUNT_W'(1) : press_count + 1'b1;
        end else if (clear_count) begin
            press_count <= '0;
        end
    end

    assign btn_level = (state == ST_PRESSED);

endmodule

// File: tb/tb_lab62_key_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for lab62_key_conditioner with DEBOUNCE_CYCLES=4, PCOUNT_W=3.
// Two instances share clock/reset: dut_a (ACTIVE_LOW=1) and dut_b
// (ACTIVE_LOW=0, driven with the inverted pin so its timing must match).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// the edge that the vector was applied to.
// -----------------------------------------------------------------------------
module tb_lab62_key_conditioner;

    localparam int PCW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic           key_a = 1'b1;
    logic           key_b = 1'b0;
    logic           clear_count = 1'b0;
    logic           level_a, press_a, release_a;
    logic           level_b, press_b, release_b;
    logic [PCW-1:0] count_a, count_b;

    lab62_key_conditioner #(
        .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1), .PCOUNT_W(PCW)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .key_raw(key_a), .clear_count(clear_count),
        .btn_level(level_a), .press_pulse(press_a), .release_pulse(release_a),
        .press_count(count_a)
    );

    lab62_key_conditioner #(
        .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0), .PCOUNT_W(PCW)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .key_raw(key_b), .clear_count(clear_count),
        .btn_level(level_b), .press_pulse(press_b), .release_pulse(release_b),
        .press_count(count_b)
    );

    // ---------------- vector table ----------------
    typedef struct packed {
        logic           key;   // raw pin for dut_a (dut_b gets the inverse)
        logic           clr;
        logic           lvl;
        logic           pp;
        logic           rp;
        logic [PCW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int failures = 0;

    task automatic add_rep(input int n, input logic key, input logic clr,
                           input logic lvl, input logic pp, input logic rp,
                           input logic [PCW-1:0] cnt);
        vec_t v;
        v = '{key: key, clr: clr, lvl: lvl, pp: pp, rp: rp, cnt: cnt};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic pressed);
        key_a = ~pressed;
        key_b = pressed;
    endtask

    // Full press then full release; clr asserts clear_count on the
    // accepting edge only.
    task automatic press_cycle(input logic clr, input logic [PCW-1:0] exp_cnt);
        set_key(1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("press_wait_level", level_a, 1'b0);
        end
        clear_count = clr;
        step();
        clear_count = 1'b0;
        check("press_accept_level", level_a, 1'b1);
        check("press_accept_pulse", press_a, 1'b1);
        check("press_accept_count", count_a, exp_cnt);
        check("press_accept_level_b", level_b, 1'b1);
        step();
        check("press_pulse_single", press_a, 1'b0);
        set_key(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("release_wait_level", level_a, 1'b1);
        end
        step();
        check("release_level", level_a, 1'b0);
        check("release_pulse", release_a, 1'b1);
        check("release_count", count_a, exp_cnt);
    endtask

    // ---------------- test ----------------
    initial begin
        // clean press, glitchy release, bounced press (cumulative count)
        add_rep(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        add_rep(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        add_rep(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        add_rep(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        add_rep(3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        add_rep(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        add_rep(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
        add_rep(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        add_rep(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        add_rep(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        add_rep(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        add_rep(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        add_rep(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        add_rep(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        add_rep(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        add_rep(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

        // reset state
        step();
        step();
        check("reset_level", level_a, 1'b0);
        check("reset_count", count_a, 3'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            key_a = vecs[i].key;
            key_b = ~vecs[i].key;
            clear_count = vecs[i].clr;
            step();
            check($sformatf("vec%0d_level", i), level_a, vecs[i].lvl);
            check($sformatf("vec%0d_press", i), press_a, vecs[i].pp);
            check($sformatf("vec%0d_release", i), release_a, vecs[i].rp);
            check($sformatf("vec%0d_count", i), count_a, vecs[i].cnt);
            check($sformatf("vec%0d_level_b", i), level_b, vecs[i].lvl);
            check($sformatf("vec%0d_press_b", i), press_b, vecs[i].pp);
        end

        // reset while pressed: outputs drop before the next edge
        reset_n = 1'b0;
        #2;
        check("rst_pressed_level", level_a, 1'b0);
        check("rst_pressed_count", count_a, 3'd0);
        check("rst_pressed_pulses", {press_a, release_a}, 2'b00);

        // key still held across deassert: treated as a brand new press
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_hold_wait", level_a, 1'b0);
        end
        step();
        check("rst_hold_level", level_a, 1'b1);
        check("rst_hold_pulse", press_a, 1'b1);
        check("rst_hold_count", count_a, 3'd1);
        step();
        check("rst_hold_pulse_once", press_a, 1'b0);

        // release, then reset at debounce count 2 of a new press
        set_key(1'b0);
        for (int i = 0; i < 6; i++) step();
        check("pre_mid_release", level_a, 1'b0);
        set_key(1'b1);
        for (int i = 0; i < 4; i++) step();
        check("mid_deb_level", level_a, 1'b0);
        reset_n = 1'b0;
        #2;
        check("rst_mid_count", count_a, 3'd0);
        check("rst_mid_level", level_a, 1'b0);
        set_key(1'b0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", {level_a, count_a}, 4'd0);
        end

        // wrap: counts 1..7 then 0, collision gives 1, clear alone gives 0
        for (int i = 1; i <= 8; i++) press_cycle(1'b0, PCW'(i));
        press_cycle(1'b1, 3'd1);
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        check("clear_alone", count_a, 3'd0);

        // active-high instance with its pin stuck low never asserts
        key_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("stuck_low_b", level_b, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab62_key_conditioner.md
Name: lab62_key_conditioner

Overview:
Conditions one raw pushbutton pin (DE10-Lite KEY, active-low) into a clean, glitch-free level for the SoC's 1-bit PIO input port ("add/accumulate" key). Sits directly upstream of that PIO: the btn_level output drives the PIO's in_port. It also provides single-cycle press/release strobes and a press counter for local logic and debug LEDs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before an accepted level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES.
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
PCOUNT_W, 8, width of press_count.

Ports:
clk  input  1  system clock, 50 MHz; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset; one clock domain, no other resets.
key_raw  input  1  asynchronous pushbutton pin, bouncing.
clear_count  input  1  synchronous clear of press_count, level-sensitive.
btn_level  output  1  debounced state, 1 = pressed; feeds PIO in_port.
press_pulse  output  1  one-cycle strobe on btn_level 0->1.
release_pulse  output  1  one-cycle strobe on btn_level 1->0.
press_count  output  PCOUNT_W  number of accepted presses, wraps modulo 2^PCOUNT_W.

Behaviour:
- Normalise: pressed_n = ACTIVE_LOW ? ~key_raw : key_raw (combinational, before the synchroniser).
- Synchroniser: two flops, sync1 <= pressed_n, sync2 <= sync1; both reset to 0 (released). Only sync2 is used downstream.
- Debounce state machine, two states, state bit == btn_level:
  - RELEASED (btn_level=0): if sync2==1, cnt increments; else cnt <= 0. Transition to PRESSED on the edge where sync2==1 and cnt==DEBOUNCE_CYCLES-1; cnt <= 0 on that edge.
  - PRESSED (btn_level=1): mirror image; sync2==0 increments cnt, sync2==1 clears cnt; go to RELEASED when sync2==0 and cnt==DEBOUNCE_CYCLES-1.
  - Any sample equal to the current state clears cnt, so a single bounce restarts the count. No partial credit.
- Latency: pin held steady at the new value from edge k -> sync2 shows it after edge k+1 -> btn_level changes on edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles after the first sampling edge counting that edge.
- Pulses: press_pulse is registered and asserted for exactly the one cycle following the RELEASED->PRESSED transition edge, i.e. it is coincident with the first cycle btn_level==1. release_pulse is the same for PRESSED->RELEASED. They are never both high. There are never two pulses without an intervening opposite transition.
- press_count: increments by 1 on the same edge that raises btn_level. It wraps from 2^PCOUNT_W-1 to 0.
  - clear_count high on an edge sets it to 0.
  - If clear_count and an accepted press occur on the same edge, the result is 1: the press is not lost.
- Reset, including mid-debounce or while pressed: all outputs 0, sync flops 0, cnt 0, state RELEASED, immediately and asynchronously.
  - After reset deassert with the key physically held, the block treats the hold as a new press. It requires the full DEBOUNCE_CYCLES and then emits press_pulse and increments the count.
- Counter never exceeds DEBOUNCE_CYCLES-1. No overflow path exists.
- No Avalon interface; the PIO samples btn_level, and its readdata lags btn_level by one further cycle.

Test Plan:
Run with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, PCOUNT_W=3.
1. Clean press: after reset, key_raw 1->0 held 20 cycles -> btn_level rises 6 cycles after the first sampling edge; press_pulse high 1 cycle, coincident with the first btn_level=1 cycle; press_count=1.
2. Bounce rejection: key_raw toggles 0,1,0,1 each 2 cycles, then held 0 -> no change during bounces; btn_level rises 6 cycles after the final stable 0; exactly one press_pulse; count=1.
3. Release with glitch: from pressed, key_raw=1 for 3 cycles, 0 for 1 cycle, then 1 held -> btn_level stays 1 through the glitch; falls 6 cycles after the final 1; one release_pulse; count unchanged.
4. Wrap and clear collision: 8 clean presses -> press_count 1..7 then 0. Press 9 with clear_count asserted on the accepting edge -> press_count=1. clear_count alone -> 0.
5. Reset mid-operation: assert reset_n=0 at debounce count 2, and separately while PRESSED -> all outputs 0 immediately. Deassert with key held low -> press accepted 6 cycles later, press_pulse once, count=1.
6. Polarity: ACTIVE_LOW=0, key_raw 0->1 held -> identical timing to scenario 1; key_raw stuck 0 -> btn_level never asserts.
